// File: rtl/reg_file_rd2_ctrl.sv
// reg_file_rd2_ctrl: register file, one write port, two registered read ports, background clear.
// Define REG_FILE_BYPASS_EN to forward same-edge accepted writes to matching reads.
module reg_file_rd2_ctrl #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] wAddr,
   input  logic [DATA_W-1:0] wData,
   input  logic              re0,
   input  logic [ADDR_W-1:0] rAddr0,
   output logic [DATA_W-1:0] rData0,
   output logic              rValid0,
   output logic              rErr0,
   input  logic              re1,
   input  logic [ADDR_W-1:0] rAddr1,
   output logic [DATA_W-1:0] rData1,
   output logic              rValid1,
   output logic              rErr1,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_done
);
   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
   typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_ok, ok0, ok1;
   logic [DATA_W-1:0] rd0, rd1;
   always_comb begin
      wr_ok = we && !busy && ({1'b0, wAddr} < DEPTH_L);
      ok0   = {1'b0, rAddr0} < DEPTH_L;
      ok1   = {1'b0, rAddr1} < DEPTH_L;
`ifdef REG_FILE_BYPASS_EN
      rd0   = (wr_ok && wAddr == rAddr0) ? wData : mem[rAddr0];
      rd1   = (wr_ok && wAddr == rAddr1) ? wData : mem[rAddr1];
`else
      rd0   = mem[rAddr0];
      rd1   = mem[rAddr1];
`endif
   end
   // User writes are blocked while busy, so they never collide with the clear pointer.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rData0   <= '0;
         rValid0  <= 1'b0;
         rErr0    <= 1'b0;
         rData1   <= '0;
         rValid1  <= 1'b0;
         rErr1    <= 1'b0;
         busy     <= 1'b0;
         clr_done <= 1'b0;
         ptr      <= '0;
         state    <= IDLE;
      end else begin
         if (wr_ok) mem[wAddr] <= wData;
         rValid0 <= re0;
         rErr0   <= re0 && !ok0;
         if (re0) rData0 <= ok0 ? rd0 : '0;
         rValid1 <= re1;
         rErr1   <= re1 && !ok1;
         if (re1) rData1 <= ok1 ? rd1 : '0;
         case (state)
            IDLE: if (clr_req) begin
               state <= CLEAR;
               ptr   <= '0;
               busy  <= 1'b1;
            end
            CLEAR: begin
               mem[ptr] <= '0;
               ptr      <= ptr + 1'b1;
               if (ptr == LAST) begin
                  state    <= DONE;
                  clr_done <= 1'b1;
               end
            end
            DONE: begin
               clr_done <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule
